// File: rtl/and_output_monitor.sv
// Clocked monitor for the AND-gate output: synchronises and debounces Z, then
// reports a clean level, edge pulses, a saturating rise count and a stuck-high alarm.
module and_output_monitor #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned STUCK_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Z,
    input  logic             clr,
    output logic             Zq,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] count,
    output logic             stuck
);

    localparam logic [7:0]       DB_LAST  = 8'(DEBOUNCE - 1);
    localparam logic [15:0]      HI_LIMIT = 16'(STUCK_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        LOW,
        DB_RISE,
        HIGH,
        DB_FALL
    } state_t;

    state_t           state_q, state_d;
    logic             s1, s2;
    logic [7:0]       db_q, db_d;
    logic [15:0]      hi_q, hi_d, hi_inc;
    logic             zq_d, rise_d, fall_d, stuck_d;
    logic [CNT_W-1:0] count_d;

    // State, synchroniser and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            state_q <= LOW;
            db_q    <= 8'd0;
            hi_q    <= 16'd0;
            Zq      <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            count   <= '0;
            stuck   <= 1'b0;
        end else begin
            s1      <= Z;
            s2      <= s1;
            state_q <= state_d;
            db_q    <= db_d;
            hi_q    <= hi_d;
            Zq      <= zq_d;
            rise    <= rise_d;
            fall    <= fall_d;
            count   <= count_d;
            stuck   <= stuck_d;
        end
    end

    // Debounce next-state plus counter, stuck timer and clear handling
    always_comb begin
        state_d = state_q;
        db_d    = db_q;
        zq_d    = Zq;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        hi_d    = hi_q;
        hi_inc  = hi_q + 16'd1;
        stuck_d = stuck;
        count_d = count;

        case (state_q)
            LOW: begin
                if (s2) begin
                    state_d = DB_RISE;
                    db_d    = 8'd1;
                end
            end
            DB_RISE: begin
                if (!s2) begin
                    state_d = LOW;
                    db_d    = 8'd0;
                end else if (db_q == DB_LAST) begin
                    state_d = HIGH;
                    db_d    = 8'd0;
                    zq_d    = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    db_d = db_q + 8'd1;
                end
            end
            HIGH: begin
                if (!s2) begin
                    state_d = DB_FALL;
                    db_d    = 8'd1;
                end
            end
            DB_FALL: begin
                if (s2) begin
                    state_d = HIGH;
                    db_d    = 8'd0;
                end else if (db_q == DB_LAST) begin
                    state_d = LOW;
                    db_d    = 8'd0;
                    zq_d    = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    db_d = db_q + 8'd1;
                end
            end
            default: begin
                state_d = LOW;
                db_d    = 8'd0;
            end
        endcase

        // Timer holds at the limit so long high periods cannot wrap it
        if ((state_q == HIGH || state_q == DB_FALL) && hi_q != HI_LIMIT) begin
            hi_d = hi_inc;
            if (hi_inc == HI_LIMIT) begin
                stuck_d = 1'b1;
            end
        end
        if (rise_d || fall_d) begin
            hi_d = 16'd0;
        end

        if (rise_d && count != CNT_MAX) begin
            count_d = count + CNT_W'(1);
        end

        if (clr) begin
            count_d = '0;
            stuck_d = 1'b0;
            hi_d    = 16'd0;
        end
    end

endmodule

// File: tb/tb_and_output_monitor.sv
// Scoreboard bench for and_output_monitor: stimulus queues expected edge/alarm
// events with their cycle and count; a negedge monitor pops and compares them.
module tb_and_output_monitor;

    localparam int unsigned CNT_W = 3;
    localparam int K_RISE  = 0;
    localparam int K_FALL  = 1;
    localparam int K_STUCK = 2;

    typedef struct {
        int kind;
        int cyc;
        int cnt;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             Z;
    logic             clr;
    logic             Zq, rise, fall, stuck;
    logic [CNT_W-1:0] count;

    int  cyc        = 0;
    int  vectors    = 0;
    int  miscompares = 0;
    int  rise_seen  = 0;
    int  rise_base;
    logic stuck_prev = 1'b0;
    ev_t q[$];

    and_output_monitor #(
        .CNT_W      (CNT_W),
        .DEBOUNCE   (4),
        .STUCK_LIMIT(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .Z    (Z),
        .clr  (clr),
        .Zq   (Zq),
        .rise (rise),
        .fall (fall),
        .count(count),
        .stuck(stuck)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int c, input int n);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.cnt  = n;
        q.push_back(e);
    endtask

    task automatic expect_ev(input int k, input string name);
        ev_t e;
        if (q.size() == 0) begin
            check({name, "_unexpected_at_cycle"}, cyc, -1);
        end else begin
            e = q.pop_front();
            check({name, "_kind"}, k, e.kind);
            check({name, "_cycle"}, cyc, e.cyc);
            check({name, "_count"}, int'(count), e.cnt);
        end
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic int sat7(input int n);
        return (n > 7) ? 7 : n;
    endfunction

    // Monitor: every output event must match the head of the scoreboard
    always @(negedge clk) begin
        if (rise && fall) check("rise_fall_exclusive", 1, 0);
        if (rise) begin
            rise_seen++;
            expect_ev(K_RISE, "rise");
        end
        if (fall) expect_ev(K_FALL, "fall");
        if (stuck && !stuck_prev) expect_ev(K_STUCK, "stuck");
        stuck_prev = stuck;
    end

    initial begin
        rst_n = 1'b0;
        Z     = 1'b1;
        clr   = 1'b0;

        // Reset held three edges with Z high
        for (int c = 1; c <= 3; c++) begin
            tick_to(c);
            check("reset_outputs", int'({Zq, rise, fall, count, stuck}), 0);
        end
        rst_n = 1'b1;
        push(K_RISE, 9, 1);
        push(K_STUCK, 25, 1);

        // Stuck alarm is sticky after the fall, cleared by clr
        tick_to(27);
        Z = 1'b0;
        push(K_FALL, 33, 1);
        tick_to(36);
        check("stuck_sticky", int'(stuck), 1);
        clr = 1'b1;
        tick_to(37);
        clr = 1'b0;
        check("clr_stuck", int'(stuck), 0);
        check("clr_count", int'(count), 0);

        // Three-cycle glitch is rejected
        Z = 1'b1;
        tick_to(40);
        Z = 1'b0;
        tick_to(50);
        check("glitch_zq", int'(Zq), 0);
        check("glitch_count", int'(count), 0);
        Z = 1'b1;
        push(K_RISE, 56, 1);
        tick_to(60);
        Z = 1'b0;
        push(K_FALL, 66, 1);

        // clr on the same edge as an accepted rise
        tick_to(70);
        Z = 1'b1;
        push(K_RISE, 76, 0);
        tick_to(75);
        clr = 1'b1;
        tick_to(76);
        clr = 1'b0;
        tick_to(80);
        Z = 1'b0;
        push(K_FALL, 86, 0);
        tick_to(90);
        Z = 1'b1;
        push(K_RISE, 96, 1);
        tick_to(100);
        Z = 1'b0;
        push(K_FALL, 106, 1);

        // Saturation: nine clean pulses into a 3-bit counter
        tick_to(110);
        clr = 1'b1;
        tick_to(111);
        clr = 1'b0;
        rise_base = rise_seen;
        for (int k = 0; k < 9; k++) begin
            tick_to(111 + 20 * k);
            Z = 1'b1;
            push(K_RISE, 117 + 20 * k, sat7(k + 1));
            tick_to(121 + 20 * k);
            Z = 1'b0;
            push(K_FALL, 127 + 20 * k, sat7(k + 1));
        end
        tick_to(291);
        check("sat_count", int'(count), 7);
        check("sat_rise_pulses", rise_seen - rise_base, 9);

        // Reset on the fourth edge of a debounce aborts it
        tick_to(300);
        Z = 1'b1;
        tick_to(303);
        rst_n = 1'b0;
        tick_to(304);
        Z = 1'b0;
        check("midreset_outputs", int'({Zq, rise, fall, count, stuck}), 0);
        tick_to(306);
        rst_n = 1'b1;
        tick_to(310);
        Z = 1'b1;
        push(K_RISE, 316, 1);
        tick_to(320);
        Z = 1'b0;
        push(K_FALL, 326, 1);

        tick_to(335);
        check("events_outstanding", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
